// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int          FETCH_DEPTH = 4;
  localparam logic [2:0]  FULL_COUNT  = 3'd4;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Four-entry {pc, inst} FIFO with push, pop and flush. Flush wins over
// push/pop; a pop on an empty queue is ignored.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic [2:0]  count
);

  fetch_entry_t entries [FETCH_DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_pop;

  assign do_pop    = pop && (count != 3'd0);
  assign head_pc   = entries[rd_ptr].pc;
  assign head_inst = entries[rd_ptr].inst;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        entries[wr_ptr].pc   <= push_pc;
        entries[wr_ptr].inst <= push_inst;
        wr_ptr               <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: fetch FSM, PC tracking and a 4-entry queue.
// Optional macro FETCH_PERF_CNT_EN adds the stall_cycles counter output.
//
// Handshakes: mem_req/mem_addr are held until a cycle with mem_ack, and
// mem_rdata is valid in that same cycle; the head entry is consumed in any
// cycle where inst_valid and inst_ready are both high.
module instr_fetch_queue
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [2:0]  q_count,
  output logic [1:0]  dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [31:0]  new_pc;
  logic [31:0]  pc_next4;
  logic [2:0]   post_cnt;
  logic         halt_q;
  logic         halt_eff;
  logic         pop;
  logic         push;
  logic         stay_fetch;

  assign dbg_state  = state;
  assign inst_valid = (q_count != 3'd0);
  assign pop        = inst_valid && inst_ready;
  // Only an ack in FETCH carries a word for the queue; redirect discards it.
  assign push       = (state == FETCH) && mem_ack && !redirect;
  assign new_pc     = align_word(redirect_pc);
  assign pc_next4   = fetch_pc + 32'd4;
  assign halt_eff   = halt || halt_q;
  assign post_cnt   = q_count + 3'd1 - {2'b00, pop};
  assign stay_fetch = (post_cnt < FULL_COUNT) && !halt_eff;

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (fetch_pc),
    .push_inst (mem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .head_pc   (inst_pc),
    .head_inst (inst),
    .count     (q_count)
  );

  // Fetch FSM with registered request outputs, PC and sticky halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      halt_q   <= 1'b0;
    end else begin
      if (halt) begin
        halt_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= new_pc;
            if (halt_eff) begin
              state <= HALTED;
            end else begin
              state    <= FETCH;
              mem_req  <= 1'b1;
              mem_addr <= new_pc;
            end
          end else if (halt_eff) begin
            state <= HALTED;
          end else if (q_count < FULL_COUNT) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            fetch_pc <= new_pc;
            if (!mem_ack) begin
              // Request still outstanding: keep it stable, drop its data later.
              state <= DRAIN;
            end else if (halt_eff) begin
              state   <= HALTED;
              mem_req <= 1'b0;
            end else begin
              mem_addr <= new_pc;
            end
          end else if (mem_ack) begin
            fetch_pc <= pc_next4;
            if (stay_fetch) begin
              mem_addr <= pc_next4;
            end else begin
              mem_req <= 1'b0;
              state   <= halt_eff ? HALTED : IDLE;
            end
          end
        end
        DRAIN: begin
          if (redirect) begin
            fetch_pc <= new_pc;
          end
          if (mem_ack) begin
            if (halt_eff) begin
              state   <= HALTED;
              mem_req <= 1'b0;
            end else begin
              state    <= FETCH;
              mem_addr <= redirect ? new_pc : fetch_pc;
            end
          end
        end
        HALTED: begin
          // Only reset leaves HALTED; a redirect just retargets the PC.
          mem_req <= 1'b0;
          if (redirect) begin
            fetch_pc <= new_pc;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles with an empty queue while not halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (!inst_valid && (state != HALTED) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Port clk, in, 1: rising-edge clock.
REQ-003 Port reset, in, 1: synchronous active-high reset.
REQ-004 Port mem_req, out, 1: instruction-memory read request.
REQ-005 Port mem_addr, out, 32: fetch address, word-aligned.
REQ-006 Port mem_ack, in, 1: request accepted; mem_rdata is valid in the same cycle.
REQ-007 Port mem_rdata, in, 32: fetched instruction word.
REQ-008 Port inst_valid, out, 1: queue head is valid.
REQ-009 Port inst, out, 32: head instruction word.
REQ-010 Port inst_pc, out, 32: PC of the head instruction.
REQ-011 Port inst_ready, in, 1: core consumes the head in this cycle.
REQ-012 Port redirect, in, 1: flush the queue and restart fetch; asserted for branch, jal and jalr.
REQ-013 Port redirect_pc, in, 32: restart address.
REQ-014 Port halt, in, 1: stop fetching (ecall with x17==10); sticky.
REQ-015 Port q_count, out, 3: number of valid queue entries, 0..4.

Function
REQ-016 The queue SHALL be a 4-entry FIFO of {pc, inst}; inst_valid = (q_count != 0); inst and inst_pc come from the head.
REQ-017 The FSM SHALL have the states IDLE, FETCH, DRAIN and HALTED.
REQ-018 IDLE -> FETCH when q_count < 4 and halt is low; mem_req = 1 only in FETCH or DRAIN.
REQ-019 In FETCH and DRAIN, mem_req and mem_addr SHALL stay stable until mem_ack; at most one request is outstanding.
REQ-020 FETCH with mem_ack: push {fetch_pc, mem_rdata}; fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0).
REQ-021 After that push, stay in FETCH if the post-push count < 4 and halt is low; otherwise go to IDLE, or to HALTED if halt is set. Back-to-back acks SHALL give 1 instruction/cycle.
REQ-022 Fetch latency: mem_ack in cycle N -> inst_valid in cycle N+1.
REQ-023 A pop (inst_valid & inst_ready) SHALL advance the head; a simultaneous push and pop leaves q_count unchanged.
REQ-024 Redirect, highest priority: flush the queue (q_count = 0 next cycle) and load fetch_pc = {redirect_pc[31:2], 2'b00}; a same-cycle pop or push is discarded.
REQ-025 Redirect while a request is pending without mem_ack: go to DRAIN, keep the old address until mem_ack, discard the data, then go to FETCH at the new fetch_pc.
REQ-026 Redirect in the same cycle as mem_ack: discard the data and go directly to FETCH at the new fetch_pc.
REQ-027 Halt: issue no new request; complete and enqueue any outstanding request; then go to HALTED.
REQ-028 HALTED is left only by reset; the queue keeps draining to the core; a redirect in HALTED flushes the queue but issues no fetch.
REQ-029 No push SHALL occur when q_count == 4; this is guaranteed by REQ-018 and REQ-021.

Reset
REQ-030 On reset: state = IDLE, fetch_pc = 0x00000000, q_count = 0, mem_req = 0, mem_addr = 0, inst_valid = 0, inst = 0, inst_pc = 0, halt latch cleared.
REQ-031 Reset mid-request SHALL abandon the request; any late mem_ack SHALL be ignored while in IDLE.
REQ-032 Reset SHALL override redirect and halt in the same cycle.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN, when defined: add output stall_cycles (out, 32), reset to 0, incremented each cycle with inst_valid == 0 and state != HALTED; saturates at 0xFFFFFFFF.
REQ-034 Without FETCH_PERF_CNT_EN: the port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-035 Shared package fetch_pkg SHALL hold FETCH_DEPTH = 4, RESET_PC = 32'h0, the FSM state typedef, and the queue-entry struct {pc, inst}.
REQ-036 Sub-module fetch_fifo SHALL implement the storage, pointers and count, with push, pop and flush inputs; the FSM and PC logic stay in instr_fetch_queue.

Verification
REQ-037 Reset, then mem_ack tied high, inst_ready high -> mem_addr 0, 4, 8, ... one per cycle; inst_pc trails by 1 cycle; q_count stays 0 or 1.
REQ-038 inst_ready low, mem_ack high -> exactly 4 pushes, q_count = 4, mem_req = 0; raise inst_ready for 1 cycle -> one new request issues.
REQ-039 mem_ack 3-cycle latency, redirect to 0x100 in cycle 1 of the wait -> DRAIN; old data discarded; next mem_addr = 0x100; first inst_pc = 0x100.
REQ-040 redirect_pc = 0x203 concurrent with mem_ack and a pop -> queue empty next cycle; mem_addr = 0x200; acked data not enqueued.
REQ-041 halt with one request outstanding -> that word is enqueued, then mem_req stays 0 forever; inst_valid drops after the queue drains; only reset resumes fetch from 0.
REQ-042 With FETCH_PERF_CNT_EN defined, mem_ack held low for 10 cycles after reset -> stall_cycles = 10; compile without the macro and rerun REQ-037 -> identical trace.
